narrow_pack: RTL and testbench
==============================

# narrow_pack

Saturating narrow-and-pack unit, the inverse of the datapath's sign-extension path. It accepts a stream of 16-bit signed values and narrows each one to a WIDTH-bit signed field, saturating or wrapping on overflow. Fields are packed LSB-first into 16-bit words for compact storage in data memory. It sits between the ALU/register-file write-back stream and the memory store port, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 8: field width in bits; legal values 1, 2, 4, 8. N = 16/WIDTH fields per word.
- SATURATE, 1: overflow mode. 1 clamps to the field's min/max; 0 truncates to in_data[WIDTH-1:0].
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input value offered.
- in_ready  out  1  unit can accept the offered value this cycle.
- in_data  in  16  signed input value.
- flush  in  1  request to emit the partial word (single-cycle pulse).
- out_valid  out  1  packed word available.
- out_ready  in  1  consumer takes the word this cycle.
- out_data  out  16  packed word; field k occupies bits [k*WIDTH +: WIDTH].
- out_count  out  5  number of valid fields in out_data (1..N).
- out_ovf  out  1  at least one field in out_data overflowed.

## Operation
- Fit test: a value fits when in_data[15:WIDTH-1] are all equal.
- If it fits: field = in_data[WIDTH-1:0], ovf = 0.
- If it does not fit, ovf = 1, and:
  - SATURATE=1: field = in_data[15] ? {1'b1, zeros} : {1'b0, ones}. For WIDTH=1 this gives 1 for negative and 0 for positive.
  - SATURATE=0: field = in_data[WIDTH-1:0].
- State held in the unit:
  - Accumulator acc[15:0], fill counter fill (0..N-1) and a sticky acc_ovf.
  - One output register (out_data, out_count, out_ovf, out_valid).
  - A flush_pend flag.
- Accept when in_valid && in_ready:
  - The field is written at position fill; fill increments and acc_ovf ORs in the field's ovf.
  - When fill==N-1 the completed word moves to the output register with out_count=N. acc, fill and acc_ovf clear.
- in_ready = !(fill==N-1 && out_valid && !out_ready): the unit stalls only when a word completion needs an occupied output register.
- Output register is free when !out_valid || out_ready.
- flush sets flush_pend. The pending flush executes when fill>0 and the output register is free:
  - acc moves to the output register with out_count=fill; unused upper bits are 0.
  - acc, fill, acc_ovf and flush_pend clear.
- flush_pend also clears when fill is 0, whether a full word was just emitted or nothing was held. A flush with nothing held is dropped.
- Flush in the same cycle as an accept, with the output register free: the new field is included first, then the word is emitted with out_count = fill+1.
- out_data, out_count and out_ovf are stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid=0, out_data=0, out_count=0, out_ovf=0, acc=0, fill=0, flush_pend=0. in_ready=1 after reset.
- Reset mid-word discards the partial accumulator and the pending flush, with no output.
- Latency: the word-completing accept (or executing flush) at edge t gives out_valid=1 from t onward, i.e. visible in the next cycle.
- Throughput: one value per cycle sustained while out_ready=1. A full word is emitted every N accepts.
- Back-to-back words: out_valid stays high and out_data updates on each edge where out_ready=1 and a new word completes.
- in_ready is combinational from registered state and out_ready only. There is no path from in_valid.

## Structure
- Shared package datapath_pkg holds:
  - constant DATA_W=16;
  - function legal_width(w) for an elaboration check that rejects illegal WIDTH;
  - function fields_per_word(w).
- Sub-module narrow_sat: combinational narrower with WIDTH and SATURATE parameters, in_data in, field and ovf out. The top level holds the counter, accumulator, output register and flush logic.

## Test plan
- WIDTH=8, SATURATE=1: accept 0x0012 then 0xFF80 -> out_data=0x8012, out_count=2, out_ovf=0, one cycle after the second accept.
- WIDTH=8, SATURATE=1: 0x0100 then 0xFE00 -> out_data=0x807F, out_ovf=1. With SATURATE=0, same inputs -> out_data=0x0000, out_ovf=1.
- WIDTH=4: accept 0x0001, 0xFFFF, 0x0007, 0xFFF8 -> out_data=0x87F1, out_count=4, out_ovf=0.
- WIDTH=8: accept 0x0005, pulse flush -> out_data=0x0005, out_count=1. A flush pulse with fill=0 -> no output, flush_pend cleared.
- Backpressure, WIDTH=8:
  - Hold out_ready=0 after the first word. in_ready stays 1 for the next accept, then drops at fill=1.
  - Raise out_ready -> the first word is taken and the second word is loaded on the same edge.
- Assert rst_n low with fill=1 and flush_pend=1 -> all outputs 0 immediately. After release, the next word starts at field 0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath constants and elaboration helpers.
//   DATA_W           : width of the datapath word.
//   legal_width(w)   : true when w is a supported packed-field width.
//   fields_per_word(w): number of w-bit fields in one DATA_W word.
package datapath_pkg;

  localparam int DATA_W = 16;

  function automatic bit legal_width(input int w);
    return (w == 1) || (w == 2) || (w == 4) || (w == 8);
  endfunction

  function automatic int fields_per_word(input int w);
    return DATA_W / w;
  endfunction

endpackage

// File: rtl/narrow_sat.sv
// Combinational narrower: reduces a 16-bit signed value to a WIDTH-bit signed
// field, either clamping (SATURATE=1) or truncating (SATURATE=0) on overflow.
// Ports:
//   in_data : 16-bit signed input value
//   field   : WIDTH-bit narrowed field
//   ovf     : value did not fit in WIDTH signed bits
module narrow_sat
  import datapath_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic [DATA_W-1:0] in_data,
  output logic [WIDTH-1:0]  field,
  output logic              ovf
);

  // Most negative / most positive field values; for WIDTH=1 these are 1 and 0.
  localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_VAL = ~MIN_VAL;

  // The value fits when every bit from the field's sign bit upward matches.
  logic [DATA_W-WIDTH:0] upper;
  logic                  fits;

  assign upper = in_data[DATA_W-1:WIDTH-1];
  assign fits  = (&upper) || !(|upper);

  always_comb begin
    ovf   = !fits;
    field = in_data[WIDTH-1:0];
    if (!fits && SATURATE) begin
      field = in_data[DATA_W-1] ? MIN_VAL : MAX_VAL;
    end
  end

endmodule

// File: rtl/narrow_pack.sv
// Saturating narrow-and-pack unit. Narrows a stream of 16-bit signed values
// to WIDTH-bit fields and packs them LSB-first into 16-bit words.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake, in_data is the 16-bit signed value
//   flush               : pulse requesting emission of a partial word
//   out_valid/out_ready : output handshake
//   out_data            : packed word, field k at [k*WIDTH +: WIDTH]
//   out_count           : number of valid fields in out_data
//   out_ovf             : at least one field of out_data overflowed
module narrow_pack
  import datapath_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [4:0]  out_count,
  output logic        out_ovf
);

  localparam int         N    = fields_per_word(WIDTH);
  localparam logic [4:0] LAST = 5'(N - 1);

  generate
    if (!legal_width(WIDTH)) begin : g_bad_width
      $error("narrow_pack: WIDTH must be 1, 2, 4 or 8");
    end
  endgenerate

  logic [15:0]      acc;
  logic [4:0]       fill;
  logic             acc_ovf;
  logic             flush_pend;

  logic [WIDTH-1:0] field;
  logic             field_ovf;

  narrow_sat #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_narrow_sat (
    .in_data (in_data),
    .field   (field),
    .ovf     (field_ovf)
  );

  // Only a word completion needs the output register, so stall only then.
  assign in_ready = !(fill == LAST && out_valid && !out_ready);

  logic        out_free;
  logic        accept;
  logic        word_done;
  logic        pend;
  logic        flush_go;
  logic        load;
  logic [15:0] acc_next;
  logic [4:0]  fill_next;
  logic        ovf_next;

  assign out_free  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign word_done = accept && (fill == LAST);

  // Accumulator as it looks with this cycle's field included; a flush in the
  // same cycle as an accept emits this view, so the new field goes out too.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_field
      assign acc_next[gi*WIDTH +: WIDTH] =
        (accept && fill == 5'(gi)) ? field : acc[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign fill_next = accept ? fill + 5'd1 : fill;
  assign ovf_next  = acc_ovf | (accept & field_ovf);

  // A flush with nothing held (fill_next==0) is simply dropped.
  assign pend     = flush_pend || flush;
  assign flush_go = pend && !word_done && (fill_next != 5'd0) && out_free;
  assign load     = word_done || flush_go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      fill       <= '0;
      acc_ovf    <= 1'b0;
      flush_pend <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_count  <= '0;
      out_ovf    <= 1'b0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_data   <= acc_next;
      out_count  <= word_done ? 5'(N) : fill_next;
      out_ovf    <= ovf_next;
      acc        <= '0;
      fill       <= '0;
      acc_ovf    <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      if (out_ready) begin
        out_valid <= 1'b0;
      end
      acc        <= acc_next;
      fill       <= fill_next;
      acc_ovf    <= ovf_next;
      flush_pend <= pend && (fill_next != 5'd0);
    end
  end

endmodule

// File: tb/tb_narrow_pack.sv
module tb_narrow_pack;

  // Three units: 0 = WIDTH 8 saturating, 1 = WIDTH 8 wrapping, 2 = WIDTH 4 saturating
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [15:0] in_data   [3];
  logic        flush     [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [15:0] out_data  [3];
  logic [4:0]  out_count [3];
  logic        out_ovf   [3];

  always #5 clk = ~clk;

  narrow_pack #(.WIDTH(8), .SATURATE(1'b1)) u_w8s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .flush(flush[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .out_count(out_count[0]),
    .out_ovf(out_ovf[0]));

  narrow_pack #(.WIDTH(8), .SATURATE(1'b0)) u_w8s0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .flush(flush[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .out_count(out_count[1]),
    .out_ovf(out_ovf[1]));

  narrow_pack #(.WIDTH(4), .SATURATE(1'b1)) u_w4s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .flush(flush[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .out_count(out_count[2]),
    .out_ovf(out_ovf[2]));

  typedef struct {
    logic [15:0] data;
    logic [4:0]  count;
    logic        ovf;
  } exp_t;

  // fmode: 0 = no flush, 1 = separate flush pulse after, 2 = flush with last accept
  typedef struct {
    int              dut;
    int              n;
    logic [3:0][15:0] v;
    int              fmode;
    logic [15:0]     data;
    logic [4:0]      count;
    logic            ovf;
  } vec_t;

  exp_t exp_q [3][$];
  vec_t vecs [13];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input int d, input logic [15:0] data, input logic [4:0] cnt, input logic ovf);
    exp_t e;
    e.data = data; e.count = cnt; e.ovf = ovf;
    exp_q[d].push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int d, input logic [15:0] v, input logic fl);
    int t;
    t = 0;
    in_valid[d] = 1'b1;
    in_data[d]  = v;
    flush[d]    = fl;
    while (!in_ready[d] && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready[d]) begin
      checks++; errors++;
      $display("FAIL send_timeout: dut %0d in_ready stuck low", d);
    end
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    flush[d]    = 1'b0;
  endtask

  task automatic pulse_flush(input int d);
    flush[d] = 1'b1;
    @(posedge clk); #1;
    flush[d] = 1'b0;
  endtask

  task automatic wait_drain(input int d);
    int t;
    t = 0;
    while (exp_q[d].size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_q[d].size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: dut %0d has %0d words outstanding", d, exp_q[d].size());
      exp_q[d].delete();
    end
  endtask

  // Scoreboard: a word is transferred on the rising edge following a falling
  // edge where out_valid && out_ready, so each such falling edge is one word.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst_n && out_valid[d] && out_ready[d]) begin
        if (exp_q[d].size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: dut %0d got data 0x%0h count %0d", d, out_data[d], out_count[d]);
        end else begin
          exp_t e;
          e = exp_q[d].pop_front();
          $display("dut %0d word data 0x%04h count %0d ovf %0b (expected 0x%04h %0d %0b)",
                   d, out_data[d], out_count[d], out_ovf[d], e.data, e.count, e.ovf);
          chk("word_data", 32'(out_data[d]), 32'(e.data));
          chk("word_count", 32'(out_count[d]), 32'(e.count));
          chk("word_ovf", 32'(out_ovf[d]), 32'(e.ovf));
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; in_data[d] = '0; flush[d] = 1'b0; out_ready[d] = 1'b1;
    end

    vecs[0]  = '{0, 2, {16'h0, 16'h0, 16'hFF80, 16'h0012}, 0, 16'h8012, 5'd2, 1'b0};
    vecs[1]  = '{0, 2, {16'h0, 16'h0, 16'hFE00, 16'h0100}, 0, 16'h807F, 5'd2, 1'b1};
    vecs[2]  = '{1, 2, {16'h0, 16'h0, 16'hFE00, 16'h0100}, 0, 16'h0000, 5'd2, 1'b1};
    vecs[3]  = '{2, 4, {16'hFFF8, 16'h0007, 16'hFFFF, 16'h0001}, 0, 16'h87F1, 5'd4, 1'b0};
    vecs[4]  = '{0, 1, {16'h0, 16'h0, 16'h0, 16'h0005}, 1, 16'h0005, 5'd1, 1'b0};
    vecs[5]  = '{2, 1, {16'h0, 16'h0, 16'h0, 16'h0123}, 1, 16'h0007, 5'd1, 1'b1};
    vecs[6]  = '{2, 2, {16'h0, 16'h0, 16'h8000, 16'h0000}, 1, 16'h0080, 5'd2, 1'b1};
    vecs[7]  = '{1, 2, {16'h0, 16'h0, 16'h0080, 16'h7FFF}, 0, 16'h80FF, 5'd2, 1'b1};
    vecs[8]  = '{0, 2, {16'h0, 16'h0, 16'hFF80, 16'h007F}, 0, 16'h807F, 5'd2, 1'b0};
    vecs[9]  = '{2, 2, {16'h0, 16'h0, 16'h0002, 16'h0003}, 2, 16'h0023, 5'd2, 1'b0};
    vecs[10] = '{0, 1, {16'h0, 16'h0, 16'h0, 16'h0080}, 2, 16'h007F, 5'd1, 1'b1};
    vecs[11] = '{2, 4, {16'h0001, 16'h0000, 16'hFFF7, 16'h0008}, 0, 16'h1087, 5'd4, 1'b1};
    vecs[12] = '{1, 1, {16'h0, 16'h0, 16'h0, 16'h0080}, 2, 16'h0080, 5'd1, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_out_valid", 32'(out_valid[d]), 32'd0);
      chk("reset_out_data", 32'(out_data[d]), 32'd0);
      chk("reset_out_count", 32'(out_count[d]), 32'd0);
      chk("reset_out_ovf", 32'(out_ovf[d]), 32'd0);
      chk("reset_in_ready", 32'(in_ready[d]), 32'd1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven words
    for (int i = 0; i < 13; i++) begin
      int d;
      d = vecs[i].dut;
      push(d, vecs[i].data, vecs[i].count, vecs[i].ovf);
      for (int k = 0; k < vecs[i].n; k++) begin
        send(d, vecs[i].v[k], (vecs[i].fmode == 2) && (k == vecs[i].n - 1));
      end
      if (vecs[i].fmode == 1) pulse_flush(d);
      chk("latency_out_valid", 32'(out_valid[d]), 32'd1);
      wait_drain(d);
    end

    // Flush with nothing held is dropped and leaves no pending flush behind
    pulse_flush(0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("empty_flush_no_output", 32'(out_valid[0]), 32'd0);
    end
    push(0, 16'h2211, 5'd2, 1'b0);
    send(0, 16'h0011, 1'b0);
    chk("no_stale_flush", 32'(out_valid[0]), 32'd0);
    send(0, 16'h0022, 1'b0);
    wait_drain(0);

    // Sustained throughput: four back-to-back accepts give two words
    push(0, 16'h0201, 5'd2, 1'b0);
    push(0, 16'h0403, 5'd2, 1'b0);
    for (int k = 1; k <= 4; k++) send(0, 16'(k), 1'b0);
    wait_drain(0);

    // Backpressure
    out_ready[0] = 1'b0;
    push(0, 16'h0201, 5'd2, 1'b0);
    send(0, 16'h0001, 1'b0);
    send(0, 16'h0002, 1'b0);
    chk("bp_in_ready_fill0", 32'(in_ready[0]), 32'd1);
    send(0, 16'h0003, 1'b0);
    chk("bp_in_ready_fill1", 32'(in_ready[0]), 32'd0);
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h0004;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_stall_in_ready", 32'(in_ready[0]), 32'd0);
    chk("bp_hold_out_data", 32'(out_data[0]), 32'h0201);
    chk("bp_hold_out_valid", 32'(out_valid[0]), 32'd1);
    out_ready[0] = 1'b1;
    push(0, 16'h0403, 5'd2, 1'b0);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    chk("bp_reload_valid", 32'(out_valid[0]), 32'd1);
    chk("bp_reload_data", 32'(out_data[0]), 32'h0403);
    wait_drain(0);

    // Reset with fill=1 and a flush pending behind a busy output register
    out_ready[0] = 1'b0;
    send(0, 16'h0001, 1'b0);
    send(0, 16'h0002, 1'b0);
    send(0, 16'h0055, 1'b0);
    pulse_flush(0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_out_valid", 32'(out_valid[0]), 32'd0);
    chk("mid_reset_out_data", 32'(out_data[0]), 32'd0);
    chk("mid_reset_out_count", 32'(out_count[0]), 32'd0);
    chk("mid_reset_out_ovf", 32'(out_ovf[0]), 32'd0);
    chk("mid_reset_in_ready", 32'(in_ready[0]), 32'd1);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(0, 16'h7766, 5'd2, 1'b0);
    send(0, 16'h0066, 1'b0);
    chk("post_reset_no_flush", 32'(out_valid[0]), 32'd0);
    send(0, 16'h0077, 1'b0);
    wait_drain(0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
